line_fifo_ast_sequencer: RTL

//  Read-side controller for the 5-line video FIFO. It sits between the FIFO read port and
//  the Avalon-ST Video sink.
//  - Drains 8-bit BT.656 active-video bytes from the FIFO.
//  - Frames them into Avalon-ST Video packets: header beat, LINE_BYTES x FRAME_LINES data, EOP.
//  - Honours sink backpressure through a 2-entry skid buffer.
//  - Runs entirely in the FIFO read clock domain.

---
 rtl/bt656_ast_pkg.sv | 41 ++++
 rtl/ast_skid2.sv | 50 +++++
 rtl/line_fifo_ast_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bt656_ast_pkg.sv
// Shared types and constants for the BT.656 line FIFO to Avalon-ST Video read path.
package bt656_ast_pkg;

  // Sequencer states; the control-packet states are only reachable with the control packet built in.
  typedef enum logic [2:0] {
    StIdle,
    StCtrlHdr,
    StCtrlBody,
    StVidHdr,
    StVidData,
    StDrain
  } seq_state_t;

  // Avalon-ST Video packet type nibbles carried in the header beat.
  localparam logic [3:0] PKT_VIDEO = 4'h0;
  localparam logic [3:0] PKT_CTRL  = 4'hF;

  // Index of the final control-packet beat (header is beat 0).
  localparam logic [3:0] CtrlLastIdx = 4'd9;

  // Nibble carried by control-packet beat idx (1..9): width, height, then interlace flags.
  function automatic logic [3:0] ctrl_nibble(input logic [3:0]  idx,
                                             input logic [15:0] width_px,
                                             input logic [15:0] frame_lines);
    logic [3:0] nib;
    nib = 4'h0;
    case (idx)
      4'd1:    nib = width_px[15:12];
      4'd2:    nib = width_px[11:8];
      4'd3:    nib = width_px[7:4];
      4'd4:    nib = width_px[3:0];
      4'd5:    nib = frame_lines[15:12];
      4'd6:    nib = frame_lines[11:8];
      4'd7:    nib = frame_lines[7:4];
      4'd8:    nib = frame_lines[3:0];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/ast_skid2.sv
// Two-entry skid buffer holding {eop, data[7:0]} beats between the FIFO read port and the sink.
// Head entry is always slot 0; upstream guarantees no push while full and no pop while empty.
module ast_skid2 (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_push,
  input  logic [8:0] i_push_data,
  input  logic       i_pop,
  output logic [1:0] o_count,
  output logic [8:0] o_head
);

  logic [8:0] r_mem0;
  logic [8:0] r_mem1;
  logic [1:0] r_count;

  // Storage and occupancy; a simultaneous push and pop shifts and appends with count unchanged.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_mem0  <= 9'h000;
      r_mem1  <= 9'h000;
      r_count <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == 2'd0) r_mem0 <= i_push_data;
          else                 r_mem1 <= i_push_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_mem0  <= r_mem1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_mem0 <= i_push_data;
          end else begin
            r_mem0 <= r_mem1;
            r_mem1 <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem0;

endmodule

// File: rtl/line_fifo_ast_sequencer.sv
// Read-side sequencer for the 5-line video FIFO: drains active-video bytes and frames them as
// Avalon-ST Video packets (header, LINE_BYTES x FRAME_LINES data, EOP) with sink backpressure.
// Optional build macro LINE_AST_CTRL_PKT_EN: precede every frame with a 10-beat control packet.
module line_fifo_ast_sequencer
  import bt656_ast_pkg::*;
#(
  parameter int unsigned LINE_BYTES  = 1440,
  parameter int unsigned FRAME_LINES = 288,
  parameter int unsigned WIDTH_PX    = 720
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [7:0] i_fifo_data,
  input  logic       i_fifo_empty,
  output logic       o_fifo_read,
  output logic [7:0] o_st_data,
  output logic       o_st_valid,
  output logic       o_st_sop,
  output logic       o_st_eop,
  input  logic       i_st_ready,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int unsigned ByteW      = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam int unsigned LineW      = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam int unsigned TotalBytes = LINE_BYTES * FRAME_LINES;
  localparam int unsigned ReadW      = $clog2(TotalBytes + 1);

  localparam logic [ByteW-1:0] LastByte   = ByteW'(LINE_BYTES - 1);
  localparam logic [LineW-1:0] LastLine   = LineW'(FRAME_LINES - 1);
  localparam logic [ReadW-1:0] TotalReads = ReadW'(TotalBytes);

  seq_state_t       r_state;
  seq_state_t       w_state_next;
  logic [ByteW-1:0] r_byte_cnt;
  logic [LineW-1:0] r_line_cnt;
  logic [ReadW-1:0] r_reads;
  logic             r_inflight;
  logic [3:0]       r_ctrl_idx;

  logic [1:0]       w_skid_count;
  logic [8:0]       w_skid_head;
  logic             w_push;
  logic             w_push_eop;
  logic             w_pop;
  logic             w_xfer;
  logic             w_data_phase;
  logic             w_hdr_phase;
  logic             w_eop_done;

  // The byte landing this cycle is tagged with EOP when it is the last byte of the frame.
  assign w_push       = r_inflight;
  assign w_push_eop   = (r_byte_cnt == LastByte) && (r_line_cnt == LastLine);
  assign w_data_phase = (r_state == StVidData) || (r_state == StDrain);
  assign w_hdr_phase  = (r_state == StCtrlHdr) || (r_state == StCtrlBody) ||
                        (r_state == StVidHdr);
  assign o_st_valid   = w_hdr_phase || (w_data_phase && (w_skid_count != 2'd0));
  assign w_xfer       = o_st_valid && i_st_ready;
  assign w_pop        = w_xfer && w_data_phase;
  // The EOP byte is only pushed on the edge entering DRAIN, so it can only leave from DRAIN.
  assign w_eop_done   = w_pop && w_skid_head[8] && (r_state == StDrain);
  assign o_frame_done = w_eop_done;
  assign o_busy       = (r_state != StIdle);

  ast_skid2 u_skid (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_push     (w_push),
    .i_push_data({w_push_eop, i_fifo_data}),
    .i_pop      (w_pop),
    .o_count    (w_skid_count),
    .o_head     (w_skid_head)
  );

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (i_enable && !i_fifo_empty) begin
`ifdef LINE_AST_CTRL_PKT_EN
          w_state_next = StCtrlHdr;
`else
          w_state_next = StVidHdr;
`endif
        end
      end
      StCtrlHdr:  if (w_xfer) w_state_next = StCtrlBody;
      StCtrlBody: if (w_xfer && (r_ctrl_idx == CtrlLastIdx)) w_state_next = StVidHdr;
      StVidHdr:   if (w_xfer) w_state_next = StVidData;
      StVidData:  if (w_push && w_push_eop) w_state_next = StDrain;
      StDrain:    if (w_eop_done) w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  // Beat content and FIFO read gating; reads stop once the skid plus in-flight byte would overflow.
  always_comb begin
    o_fifo_read = 1'b0;
    o_st_data   = 8'h00;
    o_st_sop    = 1'b0;
    o_st_eop    = 1'b0;
    case (r_state)
      StCtrlHdr: begin
        o_st_data = {4'h0, PKT_CTRL};
        o_st_sop  = 1'b1;
      end
      StCtrlBody: begin
        o_st_data = {4'h0, ctrl_nibble(r_ctrl_idx, 16'(WIDTH_PX), 16'(FRAME_LINES))};
        o_st_eop  = (r_ctrl_idx == CtrlLastIdx);
      end
      StVidHdr: begin
        o_st_data = {4'h0, PKT_VIDEO};
        o_st_sop  = 1'b1;
      end
      StVidData, StDrain: begin
        if (w_skid_count != 2'd0) begin
          o_st_data = w_skid_head[7:0];
          o_st_eop  = w_skid_head[8];
        end
        o_fifo_read = (r_state == StVidData) && !i_fifo_empty &&
                      ((3'(w_skid_count) + 3'(r_inflight)) < 3'd2) && (r_reads < TotalReads);
      end
      default: ;
    endcase
  end

  // Read tracking, byte/line position of landing bytes, and control-packet beat index.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_inflight <= 1'b0;
      r_reads    <= '0;
      r_byte_cnt <= '0;
      r_line_cnt <= '0;
      r_ctrl_idx <= 4'd0;
    end else begin
      r_inflight <= o_fifo_read;
      if (o_fifo_read) r_reads <= r_reads + ReadW'(1);
      if (w_push) begin
        if (w_push_eop) begin
          r_byte_cnt <= '0;
          r_line_cnt <= '0;
        end else if (r_byte_cnt == LastByte) begin
          r_byte_cnt <= '0;
          r_line_cnt <= r_line_cnt + LineW'(1);
        end else begin
          r_byte_cnt <= r_byte_cnt + ByteW'(1);
        end
      end
      if (w_eop_done) begin
        r_reads    <= '0;
        r_byte_cnt <= '0;
        r_line_cnt <= '0;
      end
      if ((r_state == StCtrlHdr) && w_xfer) begin
        r_ctrl_idx <= 4'd1;
      end else if ((r_state == StCtrlBody) && w_xfer) begin
        r_ctrl_idx <= (r_ctrl_idx == CtrlLastIdx) ? 4'd0 : r_ctrl_idx + 4'd1;
      end
    end
  end

endmodule
